// File: rtl/sensor_passagem_if.sv
// Bundle between the door beam sensors, the occupancy counter
// and the passage decoder.
interface sensor_passagem_if;
    logic       sensor_ext;
    logic       sensor_int;
    logic [1:0] capacidade_atual;
    logic       btn_add;
    logic       btn_sub;
    logic       bloqueio_entrada;
    logic       erro_passagem;

    modport master (
        output sensor_ext,
        output sensor_int,
        output capacidade_atual,
        input  btn_add,
        input  btn_sub,
        input  bloqueio_entrada,
        input  erro_passagem
    );

    modport slave (
        input  sensor_ext,
        input  sensor_int,
        input  capacidade_atual,
        output btn_add,
        output btn_sub,
        output bloqueio_entrada,
        output erro_passagem
    );
endinterface

// File: rtl/sensor_passagem.sv
// Door-passage decoder: synchronises and debounces both beams,
// tracks the break/clear order and pulses add/sub/error.
module sensor_passagem #(
    parameter int         DEBOUNCE_CICLOS = 4,
    parameter int         TIMEOUT_CICLOS  = 64,
    parameter logic [1:0] CAP_MAX         = 2'd3
) (
    input  logic               clock,
    input  logic               reset,
    sensor_passagem_if.slave   bus
);

    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [2:0] {
        OCIOSO,
        ENT_A,
        ENT_B,
        ENT_C,
        SAI_A,
        SAI_B,
        SAI_C,
        ESPERA_LIVRE
    } estado_t;

    // bit 1 = landing side (ext), bit 0 = car side (int)
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_filt;
    logic [1:0]    w_filt_nxt;
    logic [DW-1:0] r_cnt     [2];
    logic [DW-1:0] w_cnt_nxt [2];

    estado_t       r_state;
    estado_t       w_state_nxt;
    logic [TW-1:0] r_tmo;
    logic          w_tmo_on;
    logic          w_add;
    logic          w_sub;
    logic          w_err;
    logic          r_add;
    logic          r_sub;
    logic          r_err;

    // Two-flop synchronisers for the asynchronous beams
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
        end else begin
            r_s1 <= {bus.sensor_ext, bus.sensor_int};
            r_s2 <= r_s1;
        end
    end

    // Debounce: adopt the synced level after a full uninterrupted run
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_filt_nxt[k] = r_filt[k];
            w_cnt_nxt[k]  = '0;
            if (r_s2[k] != r_filt[k]) begin
                if (r_cnt[k] == DW'(DEBOUNCE_CICLOS - 1))
                    w_filt_nxt[k] = r_s2[k];
                else
                    w_cnt_nxt[k] = r_cnt[k] + DW'(1);
            end
        end
    end

    // Filtered levels and debounce counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_filt   <= 2'b00;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_filt   <= w_filt_nxt;
            r_cnt[0] <= w_cnt_nxt[0];
            r_cnt[1] <= w_cnt_nxt[1];
        end
    end

    assign w_tmo_on = (r_state != OCIOSO) && (r_state != ESPERA_LIVRE);

    // Next state and pulse decode; the FSM looks at the filter's
    // next value so state moves on the same edge the level changes
    always_comb begin
        w_state_nxt = r_state;
        w_add       = 1'b0;
        w_sub       = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            OCIOSO: begin
                case (w_filt_nxt)
                    2'b10:   w_state_nxt = ENT_A;
                    2'b01:   w_state_nxt = SAI_A;
                    2'b11: begin
                        w_state_nxt = ESPERA_LIVRE;
                        w_err       = 1'b1;
                    end
                    default: ;
                endcase
            end
            ENT_A: begin
                case (w_filt_nxt)
                    2'b11:   w_state_nxt = ENT_B;
                    2'b00:   w_state_nxt = OCIOSO;
                    default: ;
                endcase
            end
            ENT_B: begin
                case (w_filt_nxt)
                    2'b01:   w_state_nxt = ENT_C;
                    2'b10:   w_state_nxt = ENT_A;
                    default: ;
                endcase
            end
            ENT_C: begin
                case (w_filt_nxt)
                    2'b00: begin
                        w_state_nxt = OCIOSO;
                        if (bus.capacidade_atual < CAP_MAX)
                            w_add = 1'b1;
                        else
                            w_err = 1'b1;
                    end
                    2'b11:   w_state_nxt = ENT_B;
                    default: ;
                endcase
            end
            SAI_A: begin
                case (w_filt_nxt)
                    2'b11:   w_state_nxt = SAI_B;
                    2'b00:   w_state_nxt = OCIOSO;
                    default: ;
                endcase
            end
            SAI_B: begin
                case (w_filt_nxt)
                    2'b10:   w_state_nxt = SAI_C;
                    2'b01:   w_state_nxt = SAI_A;
                    default: ;
                endcase
            end
            SAI_C: begin
                case (w_filt_nxt)
                    2'b00: begin
                        w_state_nxt = OCIOSO;
                        if (bus.capacidade_atual != 2'd0)
                            w_sub = 1'b1;
                        else
                            w_err = 1'b1;
                    end
                    2'b11:   w_state_nxt = SAI_B;
                    default: ;
                endcase
            end
            ESPERA_LIVRE: begin
                if (w_filt_nxt == 2'b00)
                    w_state_nxt = OCIOSO;
            end
            default: w_state_nxt = OCIOSO;
        endcase
        // A stalled passage is abandoned only if nothing else moved it
        if (w_state_nxt == r_state && w_tmo_on &&
            r_tmo == TW'(TIMEOUT_CICLOS - 1)) begin
            w_state_nxt = ESPERA_LIVRE;
            w_err       = 1'b1;
        end
    end

    // State register, timeout counter and registered pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= OCIOSO;
            r_tmo   <= '0;
            r_add   <= 1'b0;
            r_sub   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state || !w_tmo_on)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + TW'(1);
            r_add <= w_add;
            r_sub <= w_sub;
            r_err <= w_err;
        end
    end

    assign bus.btn_add          = r_add;
    assign bus.btn_sub          = r_sub;
    assign bus.erro_passagem    = r_err;
    assign bus.bloqueio_entrada = (bus.capacidade_atual == CAP_MAX);

endmodule

// File: tb/tb_sensor_passagem.sv
// Scoreboard bench for the door-passage decoder: every pulse the
// DUT emits must match the next queued event in kind and cycle.
module tb_sensor_passagem;

    localparam int LAT  = 6;
    localparam int TMO  = 64;
    localparam int K_NO  = 0;
    localparam int K_ADD = 1;
    localparam int K_SUB = 2;
    localparam int K_ERR = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_err;
    ev_t  sb[$];

    sensor_passagem_if ifc();

    sensor_passagem dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // Monitor: compare every emitted pulse against the scoreboard
    always @(posedge clk) begin
        int  k;
        ev_t e;
        #1;
        cyc++;
        k = (ifc.btn_add ? K_ADD : 0) |
            (ifc.btn_sub ? K_SUB : 0) |
            (ifc.erro_passagem ? K_ERR : 0);
        if (rst_n && k != 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", k, K_NO);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", k, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one raw level pair for n cycles, queueing a pulse if due
    task automatic phase(input logic e, input logic i, input int n,
                         input int kind, input int lat);
        ev_t ev;
        @(negedge clk);
        ifc.sensor_ext = e;
        ifc.sensor_int = i;
        if (kind != K_NO) begin
            ev.kind = kind;
            ev.cyc  = cyc + lat;
            sb.push_back(ev);
        end
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic entry(input int kind);
        phase(1'b1, 1'b0, 10, K_NO, 0);
        phase(1'b1, 1'b1, 10, K_NO, 0);
        phase(1'b0, 1'b1, 10, K_NO, 0);
        phase(1'b0, 1'b0, 10, kind, LAT);
    endtask

    task automatic leave(input int kind);
        phase(1'b0, 1'b1, 10, K_NO, 0);
        phase(1'b1, 1'b1, 10, K_NO, 0);
        phase(1'b1, 1'b0, 10, K_NO, 0);
        phase(1'b0, 1'b0, 10, kind, LAT);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        cyc   = 0;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifc.sensor_ext       = 1'b0;
        ifc.sensor_int       = 1'b0;
        ifc.capacidade_atual = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_add", int'(ifc.btn_add), 0);
        chk("rst_sub", int'(ifc.btn_sub), 0);
        chk("rst_err", int'(ifc.erro_passagem), 0);
        chk("bloq_cap0", int'(ifc.bloqueio_entrada), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        entry(K_ADD);

        ifc.capacidade_atual = 2'd2;
        @(negedge clk);
        chk("bloq_cap2", int'(ifc.bloqueio_entrada), 0);
        leave(K_SUB);

        ifc.capacidade_atual = 2'd0;
        leave(K_ERR);

        ifc.capacidade_atual = 2'd3;
        @(negedge clk);
        chk("bloq_cap3", int'(ifc.bloqueio_entrada), 1);
        entry(K_ERR);

        ifc.capacidade_atual = 2'd1;
        phase(1'b1, 1'b0, 3, K_NO, 0);
        phase(1'b0, 1'b0, 10, K_NO, 0);

        phase(1'b1, 1'b0, 10, K_NO, 0);
        phase(1'b0, 1'b0, 10, K_NO, 0);

        phase(1'b1, 1'b0, 80, K_ERR, LAT + TMO);
        phase(1'b0, 1'b0, 10, K_NO, 0);

        phase(1'b1, 1'b1, 10, K_ERR, LAT);
        phase(1'b0, 1'b1, 10, K_NO, 0);
        phase(1'b0, 1'b0, 10, K_NO, 0);

        phase(1'b1, 1'b0, 10, K_NO, 0);
        phase(1'b1, 1'b1, 10, K_NO, 0);
        phase(1'b0, 1'b1, 10, K_NO, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_add", int'(ifc.btn_add), 0);
        chk("post_rst_err", int'(ifc.erro_passagem), 0);
        phase(1'b0, 1'b1, 10, K_NO, 0);
        phase(1'b0, 1'b0, 10, K_NO, 0);
        entry(K_ADD);

        repeat (20) @(negedge clk);
        chk("sb_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sensor_passagem.md
Name: sensor_passagem

Overview:
- Door-passage decoder for the elevator car. Two beam sensors at the door frame: sensor_ext (landing side) and sensor_int (car side).
- Decodes the order in which the beams break and clear, and emits one-cycle btn_add / btn_sub pulses.
- Those pulses drive the people-counting block, which is its consumer. The block reads back capacidade_atual to gate pulses at the full and empty limits and to drive the entry-block indication.

Parameters:
- DEBOUNCE_CICLOS, 4, consecutive stable cycles required before a filtered sensor level changes (minimum 1).
- TIMEOUT_CICLOS, 64, maximum cycles allowed in any non-idle passage state before the passage is aborted.
- CAP_MAX, 3, occupancy value treated as full; must fit in 2 bits.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- sensor_ext  in  1  raw landing-side beam, 1 = blocked; asynchronous to clock.
- sensor_int  in  1  raw car-side beam, 1 = blocked; asynchronous to clock.
- capacidade_atual  in  2  current occupancy fed back from the counter.
- btn_add  out  1  one-cycle pulse: one person entered.
- btn_sub  out  1  one-cycle pulse: one person left.
- bloqueio_entrada  out  1  level, high while capacidade_atual == CAP_MAX.
- erro_passagem  out  1  one-cycle pulse: aborted, ambiguous or rejected passage.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - btn_add = 0, btn_sub = 0, erro_passagem = 0.
  - Synchronisers, debounce counters and timeout counter cleared.
  - Filtered levels = 0; FSM = OCIOSO.
  - bloqueio_entrada is combinational from capacidade_atual and is not forced by reset.
- Input path, per sensor:
  - 2-flop synchroniser.
  - Debounce counter. The filtered level takes the synchronised value once that value has differed from the filtered level for DEBOUNCE_CICLOS consecutive cycles. Any interruption of the run restarts the count.
  - Latency from raw edge to filtered edge: 2 + DEBOUNCE_CICLOS cycles.
- FSM on the filtered pair {ext,int}:
  - OCIOSO:
    - 10 -> ENT_A (entry started).
    - 01 -> SAI_A (exit started).
    - 11 -> ESPERA_LIVRE with an erro_passagem pulse (ambiguous start).
  - Entry path:
    - ENT_A: 11 -> ENT_B; 00 -> OCIOSO with no pulse (retreat).
    - ENT_B: 01 -> ENT_C; 10 -> ENT_A (step back).
    - ENT_C: 00 -> OCIOSO and the entry completes; 11 -> ENT_B.
  - Exit path: SAI_A / SAI_B / SAI_C mirror the entry path with the sensor roles swapped. Sequence is 01, 11, 10, 00.
  - ESPERA_LIVRE: stays until the pair is 00, then -> OCIOSO. No pulses are emitted in this state.
  - Any other pair value in a given state leaves the state unchanged.
- Entry completion:
  - If capacidade_atual < CAP_MAX: btn_add high for exactly the one cycle following the transition.
  - Otherwise: btn_add stays 0 and erro_passagem pulses in that same cycle.
- Exit completion:
  - If capacidade_atual > 0: btn_sub pulses.
  - Otherwise: erro_passagem pulses.
- btn_add and btn_sub are never high in the same cycle, and each completed passage produces at most one pulse.
- Timeout:
  - The counter runs in every state except OCIOSO and ESPERA_LIVRE, and clears on every state change.
  - Reaching TIMEOUT_CICLOS -> ESPERA_LIVRE with an erro_passagem pulse.
- bloqueio_entrada = (capacidade_atual == CAP_MAX), combinational.
- Reset mid-passage: the passage is discarded, no pulse is emitted, and the FSM restarts in OCIOSO. Sensors still blocked after reset are re-filtered from 0.

Test Plan:
- Entry: reset low for 2 cycles; capacidade_atual = 0; raw ext=1; then int=1; then ext=0; then int=0, each level held 10 cycles -> exactly one btn_add pulse, 1 cycle wide, (2+4) cycles after int falls; btn_sub = 0 throughout.
- Exit with capacidade_atual = 2: sequence int, both, ext, none -> one btn_sub pulse; then repeat with capacidade_atual = 0 -> no btn_sub, one erro_passagem pulse.
- Full car: capacidade_atual = 3 -> bloqueio_entrada = 1; a complete entry sequence -> btn_add stays 0, one erro_passagem pulse.
- Glitch/retreat:
  - ext pulsed high for 3 cycles -> filtered level never changes, no outputs.
  - ext held 10 cycles then released without int -> FSM back to OCIOSO, no pulses.
- Timeout and ambiguity:
  - ext held high for 80 cycles -> erro_passagem pulses 64 cycles after ENT_A is entered; no btn_add follows when ext is released.
  - Both raw sensors rise in the same cycle -> erro_passagem; no pulses until both are low.
- Reset mid-passage: reset asserted while in ENT_C -> no btn_add at any point; state is OCIOSO one cycle after reset is released; a fresh entry then counts normally.
